// File: rtl/cb_exec_unit.sv
// CB-prefix instruction sequencer sitting in front of the ALU.
// Decodes the CB opcode byte, fetches the operand from the register file or
// from memory at (HL), runs the ALU, and writes the result and flags back.
// Memory operands use a read-modify-write with a request/ready handshake.
module cb_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  cb_op,
  input  logic [15:0] hl,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_rd_idx,
  input  logic [7:0]  rf_rd_data,
  output logic        rf_we,
  output logic [2:0]  rf_wr_idx,
  output logic [7:0]  rf_wr_data,
  output logic        flags_we,
  output logic [3:0]  flags_out,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  alu_op,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [3:0]  alu_fin,
  input  logic [15:0] alu_o,
  input  logic [3:0]  alu_fout
);

  typedef enum logic [2:0] {IDLE, EXEC, MRD, MEXEC, MWR} state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  opLat;
  logic [15:0] hlLat;
  logic [7:0]  resultLat;
  logic [7:0]  memByte;
  logic        isBit;
  logic        isResSet;
  logic        unusedAluHi;

  // Only the low byte of the ALU result carries CB results.
  assign unusedAluHi = ^alu_o[15:8];

  assign isBit    = (opLat[7:6] == 2'b01);
  assign isResSet = opLat[7];

  // Map the CB opcode byte onto the ALU operation code.
  function automatic logic [7:0] decodeOp(input logic [7:0] op);
    logic [7:0] aluCode;
    aluCode = 8'h00;
    case (op[7:6])
      2'b00: begin
        case (op[5:3])
          3'd0:    aluCode = 8'h10;
          3'd1:    aluCode = 8'h11;
          3'd2:    aluCode = 8'h12;
          3'd3:    aluCode = 8'h13;
          3'd4:    aluCode = 8'h24;
          3'd5:    aluCode = 8'h25;
          3'd6:    aluCode = 8'h27;
          default: aluCode = 8'h26;
        endcase
      end
      2'b01:   aluCode = {4'h3, 1'b0, op[5:3]};
      2'b10:   aluCode = {4'h4, 1'b0, op[5:3]};
      default: aluCode = {4'h5, 1'b0, op[5:3]};
    endcase
    return aluCode;
  endfunction

  // State register plus the operand/result latches; reset clears them all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      opLat     <= 8'h00;
      hlLat     <= 16'h0000;
      resultLat <= 8'h00;
      memByte   <= 8'h00;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        opLat <= cb_op;
        hlLat <= hl;
      end
      if (state == MRD && mem_ready) memByte <= mem_rdata;
      if (state == MEXEC) resultLat <= alu_o[7:0];
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    stateNext  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    rf_rd_idx  = 3'd0;
    rf_we      = 1'b0;
    rf_wr_idx  = 3'd0;
    rf_wr_data = 8'h00;
    flags_we   = 1'b0;
    flags_out  = isBit ? {alu_fout[3:1], flags_in[0]} : alu_fout;
    mem_addr   = 16'h0000;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = 8'h00;
    alu_op     = (state == IDLE) ? 8'h00 : decodeOp(opLat);
    alu_x      = 16'h0000;
    alu_y      = 16'h0000;
    alu_fin    = flags_in;
    case (state)
      IDLE: begin
        if (start) stateNext = (cb_op[2:0] == 3'd6) ? MRD : EXEC;
      end
      EXEC: begin
        rf_rd_idx  = opLat[2:0];
        alu_x      = {8'h00, rf_rd_data};
        rf_we      = !isBit;
        rf_wr_idx  = opLat[2:0];
        rf_wr_data = alu_o[7:0];
        flags_we   = !isResSet;
        done       = 1'b1;
        stateNext  = IDLE;
      end
      MRD: begin
        mem_rd   = 1'b1;
        mem_addr = hlLat;
        if (mem_ready) stateNext = MEXEC;
      end
      MEXEC: begin
        alu_x     = {8'h00, memByte};
        flags_we  = !isResSet;
        done      = isBit;
        stateNext = isBit ? IDLE : MWR;
      end
      MWR: begin
        mem_wr    = 1'b1;
        mem_addr  = hlLat;
        mem_wdata = resultLat;
        if (mem_ready) begin
          done      = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cb_exec_unit.sv
// Testbench for cb_exec_unit: stub ALU, register file and wait-state memory,
// fixed vectors, random instructions against a reference model, and a
// reset-during-access sequence.
module tb_cb_exec_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  cbOp;
  logic [15:0] hlIn;
  logic [3:0]  flagsIn;
  logic        busy, done;
  logic [2:0]  rfRdIdx, rfWrIdx;
  logic [7:0]  rfRdData, rfWrData;
  logic        rfWe, flagsWe;
  logic [3:0]  flagsOut;
  logic [15:0] memAddr;
  logic        memRd, memWr, memReady;
  logic [7:0]  memWdata, memRdata;
  logic [7:0]  aluOp;
  logic [15:0] aluX, aluY, aluO;
  logic [3:0]  aluFin, aluFout;

  logic [7:0]  rf [8];
  logic [7:0]  memVal;
  int          memWait;
  int          waitCnt;

  int nChecks = 0;
  int nFail   = 0;

  // observation record of one instruction
  int          wrCnt, flCnt, doneCnt, doneCyc, rdCyc, wrCyc, protoErr, idleErr;
  logic [7:0]  wrData;
  logic [2:0]  wrIdx;
  logic [3:0]  flVal;

  always #5 clk = ~clk;

  cb_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .cb_op(cbOp), .hl(hlIn),
    .flags_in(flagsIn), .busy(busy), .done(done), .rf_rd_idx(rfRdIdx),
    .rf_rd_data(rfRdData), .rf_we(rfWe), .rf_wr_idx(rfWrIdx),
    .rf_wr_data(rfWrData), .flags_we(flagsWe), .flags_out(flagsOut),
    .mem_addr(memAddr), .mem_rd(memRd), .mem_wr(memWr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_ready(memReady), .alu_op(aluOp), .alu_x(aluX),
    .alu_y(aluY), .alu_fin(aluFin), .alu_o(aluO), .alu_fout(aluFout)
  );

  assign rfRdData = rf[rfRdIdx];
  assign memReady = (memRd || memWr) && (waitCnt >= memWait);
  assign memRdata = memReady ? memVal : 8'h5A;

  always @(posedge clk) begin
    if (!(memRd || memWr) || memReady) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  // Stub ALU keyed on ALU op codes. BIT reports C=0 on purpose so the
  // unit's carry preservation is visible.
  function automatic logic [19:0] aluStub(input logic [7:0] op, input logic [15:0] xw, input logic [3:0] fin);
    logic [7:0] x, r;
    logic c;
    logic [3:0] f;
    x = xw[7:0]; r = 8'hDE; c = 1'b0; f = 4'h0;
    case (op)
      8'h10: begin r = {x[6:0], x[7]};   c = x[7]; end
      8'h11: begin r = {x[0], x[7:1]};   c = x[0]; end
      8'h12: begin r = {x[6:0], fin[0]}; c = x[7]; end
      8'h13: begin r = {fin[0], x[7:1]}; c = x[0]; end
      8'h24: begin r = {x[6:0], 1'b0};   c = x[7]; end
      8'h25: begin r = {x[7], x[7:1]};   c = x[0]; end
      8'h26: begin r = {1'b0, x[7:1]};   c = x[0]; end
      8'h27: begin r = {x[3:0], x[7:4]}; c = 1'b0; end
      default: ;
    endcase
    f = {r == 8'h00, 1'b0, 1'b0, c};
    if (op[7:4] == 4'h3) begin r = 8'hEE; f = {~x[op[2:0]], 1'b0, 1'b1, 1'b0}; end
    if (op[7:4] == 4'h4) begin r = x & ~(8'd1 << op[2:0]); f = 4'b0110; end
    if (op[7:4] == 4'h5) begin r = x | (8'd1 << op[2:0]);  f = 4'b0110; end
    return {8'h00, r, f};
  endfunction

  always_comb {aluO, aluFout} = aluStub(aluOp, aluX, aluFin);

  // Reference semantics of a CB instruction, straight from the opcode byte.
  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flags;
    logic       doWrite;
    logic       doFlags;
  } ref_t;

  function automatic ref_t refOp(input logic [7:0] op, input logic [7:0] x, input logic [3:0] fin);
    ref_t o;
    int b;
    logic c;
    b = int'(op[5:3]);
    o = '0; c = 1'b0;
    if (op[7:6] == 2'b00) begin
      case (b)
        0: begin o.res = (x << 1) | (x >> 7);        c = x[7]; end
        1: begin o.res = (x >> 1) | (x << 7);        c = x[0]; end
        2: begin o.res = (x << 1) | 8'(fin[0]);      c = x[7]; end
        3: begin o.res = (x >> 1) | (8'(fin[0]) << 7); c = x[0]; end
        4: begin o.res = x << 1;                      c = x[7]; end
        5: begin o.res = (x >> 1) | (x & 8'h80);     c = x[0]; end
        6: begin o.res = (x << 4) | (x >> 4);        c = 1'b0; end
        default: begin o.res = x >> 1;                c = x[0]; end
      endcase
      o.flags = {o.res == 8'h00, 1'b0, 1'b0, c};
      o.doWrite = 1'b1; o.doFlags = 1'b1;
    end else if (op[7:6] == 2'b01) begin
      o.flags = {((x >> b) & 8'd1) == 8'd0, 1'b0, 1'b1, fin[0]};
      o.doFlags = 1'b1;
    end else begin
      o.res = (op[7:6] == 2'b10) ? (x & ~(8'd1 << b)) : (x | (8'd1 << b));
      o.doWrite = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one instruction and record everything the unit does until done.
  task automatic runInstr(input logic [7:0] op, input logic [15:0] hlv, input logic [7:0] operand,
                          input logic [3:0] fin, input int waitN);
    memWait = waitN; flagsIn = fin;
    if (op[2:0] == 3'd6) memVal = operand; else rf[op[2:0]] = operand;
    wrCnt = 0; flCnt = 0; doneCnt = 0; doneCyc = -1; rdCyc = 0; wrCyc = 0;
    protoErr = 0; idleErr = 0; wrData = 8'h00; wrIdx = 3'd0; flVal = 4'h0;
    cbOp = op; hlIn = hlv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cbOp = 8'($urandom); hlIn = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (rfWe) begin wrCnt++; wrData = rfWrData; wrIdx = rfWrIdx; rf[rfWrIdx] = rfWrData; end
      if (memRd) begin rdCyc++; if (memAddr !== hlv) protoErr++; end
      if (memWr) begin
        wrCyc++;
        if (memAddr !== hlv) protoErr++;
        if (memReady) begin wrCnt++; wrData = memWdata; wrIdx = 3'd6; memVal = memWdata; end
      end
      if (memRd && memWr) protoErr++;
      if (flagsWe) begin flCnt++; flVal = flagsOut; end
      if (done) begin doneCnt++; doneCyc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
    idleErr = int'({busy, done, rfWe, flagsWe, memRd, memWr} != 6'b0);
  endtask

  task automatic checkInstr(input string nm, input logic [7:0] op, input int expWr, input logic [7:0] expData,
                            input int expFlWe, input logic [3:0] expFlags, input int expDone,
                            input int expRd, input int expWrCyc);
    check({nm, " done cycle"}, doneCyc, expDone);
    check({nm, " done count"}, doneCnt, 1);
    check({nm, " write count"}, wrCnt, expWr);
    if (expWr != 0) begin
      check({nm, " write data"}, wrData, expData);
      check({nm, " write index"}, wrIdx, op[2:0]);
    end
    check({nm, " flags_we count"}, flCnt, expFlWe);
    if (expFlWe != 0) check({nm, " flags"}, flVal, expFlags);
    check({nm, " mem_rd cycles"}, rdCyc, expRd);
    check({nm, " mem_wr cycles"}, wrCyc, expWrCyc);
    check({nm, " bus protocol errors"}, protoErr, 0);
    check({nm, " idle after done"}, idleErr, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] hl;
    logic [7:0]  operand;
    logic [3:0]  fin;
    int          waitN;
    logic [7:0]  expData;
    logic [3:0]  expFlags;
    int          expWr;
    int          expFlWe;
    int          expDone;
    int          expRd;
    int          expWrCyc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{8'h00, 16'h0000, 8'h85, 4'h0, 0, 8'h0B, 4'b0001, 1, 1, 1, 0, 0}; // RLC B
    vecs[1] = '{8'h7C, 16'h0000, 8'h00, 4'h1, 0, 8'h00, 4'b1011, 0, 1, 1, 0, 0}; // BIT 7,H
    vecs[2] = '{8'hC6, 16'hC000, 8'h10, 4'h0, 2, 8'h11, 4'h0,    1, 0, 7, 3, 3}; // SET 0,(HL) wait 2
    vecs[3] = '{8'h36, 16'h8001, 8'hF0, 4'hF, 0, 8'h0F, 4'b0000, 1, 1, 3, 1, 1}; // SWAP (HL)
    vecs[4] = '{8'h46, 16'h4321, 8'hFE, 4'h0, 0, 8'h00, 4'b1010, 0, 1, 2, 1, 0}; // BIT 0,(HL)
    vecs[5] = '{8'h3F, 16'h0000, 8'h01, 4'h0, 0, 8'h00, 4'b1001, 1, 1, 1, 0, 0}; // SRL A
    vecs[6] = '{8'h1E, 16'h2222, 8'h01, 4'h1, 1, 8'h80, 4'b0001, 1, 1, 5, 2, 2}; // RR (HL) wait 1
    vecs[7] = '{8'h9D, 16'h0000, 8'hFF, 4'h0, 0, 8'hF7, 4'h0,    1, 0, 1, 0, 0}; // RES 3,L

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    memVal = 8'h00; memWait = 0;
    reset = 1'b1; start = 1'b0; cbOp = 8'h00; hlIn = 16'h0000; flagsIn = 4'h0;
    repeat (2) @(negedge clk);
    check("reset strobes", {busy, done, rfWe, flagsWe, memRd, memWr}, 6'b0);
    check("reset alu_op", aluOp, 8'h00);
    check("reset mem_addr", memAddr, 16'h0000);
    check("reset rf indices", {rfRdIdx, rfWrIdx}, 6'b0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      runInstr(vecs[i].op, vecs[i].hl, vecs[i].operand, vecs[i].fin, vecs[i].waitN);
      checkInstr($sformatf("vec%0d", i), vecs[i].op, vecs[i].expWr, vecs[i].expData, vecs[i].expFlWe,
                 vecs[i].expFlags, vecs[i].expDone, vecs[i].expRd, vecs[i].expWrCyc);
    end

    // Random instructions against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] op, x;
      logic [3:0] fin;
      int w, eDone, eRd, eWr;
      logic isMem;
      ref_t r;
      op = 8'($urandom); x = 8'($urandom); fin = 4'($urandom); w = $urandom_range(0, 2);
      isMem = (op[2:0] == 3'd6);
      r = refOp(op, x, fin);
      eRd = isMem ? w + 1 : 0;
      eWr = (isMem && r.doWrite) ? w + 1 : 0;
      eDone = !isMem ? 1 : (r.doWrite ? 2 * w + 3 : w + 2);
      runInstr(op, 16'($urandom), x, fin, w);
      checkInstr($sformatf("rnd%0d op%02h", i, op), op, int'(r.doWrite), r.res, int'(r.doFlags),
                 r.flags, eDone, eRd, eWr);
    end

    // start while busy is ignored; reset during MRD abandons the access.
    memWait = 5; memVal = 8'h10; flagsIn = 4'h0;
    cbOp = 8'hC6; hlIn = 16'hC000; start = 1'b1;
    @(negedge clk);
    check("T6 in MRD", memRd, 1'b1);
    cbOp = 8'h00; hlIn = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("T6 start ignored mem_rd", memRd, 1'b1);
    check("T6 start ignored addr", memAddr, 16'hC000);
    check("T6 start ignored alu_op", aluOp, 8'h50);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("T6 reset busy", busy, 1'b0);
    check("T6 reset mem_rd", memRd, 1'b0);
    begin
      int strobes;
      strobes = 0;
      for (int c = 0; c < 5; c++) begin
        if (busy || done || rfWe || flagsWe || memWr || memRd) strobes++;
        @(negedge clk);
      end
      check("T6 no activity after reset", strobes, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
